// File: rtl/mem_access_pkg.sv
// Shared types and opcode helpers for the load/store access block.
package mem_access_pkg;

  typedef enum logic [3:0] {
    OP_LW  = 4'd0,
    OP_LH  = 4'd1,
    OP_LHU = 4'd2,
    OP_LB  = 4'd3,
    OP_LBU = 4'd4,
    OP_SW  = 4'd5,
    OP_SH  = 4'd6,
    OP_SB  = 4'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  function automatic logic op_supported(input opcode_t op);
    case (op)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input opcode_t op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic op_aligned(input opcode_t op, input logic [1:0] offset);
    case (op)
      OP_LW, OP_SW:         return offset == 2'b00;
      OP_LH, OP_LHU, OP_SH: return offset[0] == 1'b0;
      default:              return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering for stores and lane select/extension for loads.
module mem_align
  import mem_access_pkg::*;
(
  input  opcode_t     opcode,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic [3:0]  byteenable,
  output logic [31:0] write_data,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Little-endian: byte at offset k sits on bits [8k+7:8k].
  assign lane_byte = read_data[{offset, 3'b000} +: 8];
  assign lane_half = read_data[{offset[1], 4'b0000} +: 16];

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    byteenable = 4'b1111;
    write_data = store_data;
    load_data  = read_data;
    case (opcode)
      OP_LB:  load_data = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU: load_data = {24'h000000, lane_byte};
      OP_LH:  load_data = {{16{lane_half[15]}}, lane_half};
      OP_LHU: load_data = {16'h0000, lane_half};
      OP_SH: begin
        byteenable = offset[1] ? 4'b1100 : 4'b0011;
        write_data = {2{store_data[15:0]}};
      end
      OP_SB: begin
        byteenable = 4'b0001 << offset;
        write_data = {4{store_data[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Load/store bus master: IDLE -> ACCESS -> DONE with wait-timeout and alignment checks.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  opcode_t     opcode_i,
  input  logic [31:0] effective_address_i,
  input  logic [31:0] store_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        addr_error_o,
  output logic        bus_error_o,
  output logic [31:0] mem_address_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [3:0]  mem_byteenable_o,
  output logic [31:0] mem_writedata_o,
  input  logic [31:0] mem_readdata_i,
  input  logic        mem_waitrequest_i
);

  localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  mem_state_t     state_q, state_d;
  opcode_t        op_q, op_d;
  logic [1:0]     off_q, off_d;
  logic [WCW-1:0] wait_q, wait_d;

  logic        busy_d, done_d, addr_err_d, bus_err_d, rd_d, wr_d;
  logic [31:0] load_d, addr_d, wd_d;
  logic [3:0]  be_d;

  opcode_t     align_op;
  logic [1:0]  align_off;
  logic [3:0]  align_be;
  logic [31:0] align_wd, align_load;

  // One aligner serves both phases: incoming request in IDLE, latched request afterwards.
  assign align_op  = (state_q == IDLE) ? opcode_i : op_q;
  assign align_off = (state_q == IDLE) ? effective_address_i[1:0] : off_q;

  mem_align u_align (
    .opcode     (align_op),
    .offset     (align_off),
    .store_data (store_data_i),
    .read_data  (mem_readdata_i),
    .byteenable (align_be),
    .write_data (align_wd),
    .load_data  (align_load)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    off_d      = off_q;
    wait_d     = wait_q;
    busy_d     = busy_o;
    done_d     = 1'b0;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    load_d     = load_data_o;
    rd_d       = mem_read_o;
    wr_d       = mem_write_o;
    addr_d     = mem_address_o;
    be_d       = mem_byteenable_o;
    wd_d       = mem_writedata_o;
    case (state_q)
      IDLE: begin
        if (start_i && op_supported(opcode_i)) begin
          op_d  = opcode_i;
          off_d = effective_address_i[1:0];
          if (!op_aligned(opcode_i, effective_address_i[1:0])) begin
            state_d    = DONE;
            done_d     = 1'b1;
            addr_err_d = 1'b1;
          end else begin
            state_d = ACCESS;
            busy_d  = 1'b1;
            wait_d  = '0;
            rd_d    = !op_is_store(opcode_i);
            wr_d    = op_is_store(opcode_i);
            addr_d  = {effective_address_i[31:2], 2'b00};
            be_d    = align_be;
            wd_d    = align_wd;
          end
        end
      end
      ACCESS: begin
        if (!mem_waitrequest_i) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (mem_read_o) load_d = align_load;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          busy_d    = 1'b0;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q          <= IDLE;
      op_q             <= OP_LW;
      off_q            <= 2'b00;
      wait_q           <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      addr_error_o     <= 1'b0;
      bus_error_o      <= 1'b0;
      load_data_o      <= 32'h0;
      mem_read_o       <= 1'b0;
      mem_write_o      <= 1'b0;
      mem_address_o    <= 32'h0;
      mem_byteenable_o <= 4'h0;
      mem_writedata_o  <= 32'h0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      off_q            <= off_d;
      wait_q           <= wait_d;
      busy_o           <= busy_d;
      done_o           <= done_d;
      addr_error_o     <= addr_err_d;
      bus_error_o      <= bus_err_d;
      load_data_o      <= load_d;
      mem_read_o       <= rd_d;
      mem_write_o      <= wr_d;
      mem_address_o    <= addr_d;
      mem_byteenable_o <= be_d;
      mem_writedata_o  <= wd_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected bus requests and completions are queued at issue.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        reset_n_i;
  logic        start_i;
  opcode_t     opcode_i;
  logic [31:0] effective_address_i;
  logic [31:0] store_data_i;
  logic        busy_o, done_o, addr_error_o, bus_error_o;
  logic [31:0] load_data_o, mem_address_o, mem_writedata_o;
  logic        mem_read_o, mem_write_o;
  logic [3:0]  mem_byteenable_o;
  logic [31:0] mem_readdata_i;
  logic        mem_waitrequest_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          chk_wd;
  } bus_exp_t;

  typedef struct {
    logic        addr_err;
    logic        bus_err;
    logic [31:0] load;
    bit          chk_load;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];

  mem_access #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk                 (clk),
    .reset_n_i           (reset_n_i),
    .start_i             (start_i),
    .opcode_i            (opcode_i),
    .effective_address_i (effective_address_i),
    .store_data_i        (store_data_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .load_data_o         (load_data_o),
    .addr_error_o        (addr_error_o),
    .bus_error_o         (bus_error_o),
    .mem_address_o       (mem_address_o),
    .mem_read_o          (mem_read_o),
    .mem_write_o         (mem_write_o),
    .mem_byteenable_o    (mem_byteenable_o),
    .mem_writedata_o     (mem_writedata_o),
    .mem_readdata_i      (mem_readdata_i),
    .mem_waitrequest_i   (mem_waitrequest_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model, written independently of the RTL's part-select style.
  function automatic bit m_aligned(input opcode_t op, input logic [1:0] off);
    if (op == OP_LW || op == OP_SW) return off == 2'd0;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return (off == 2'd0) || (off == 2'd2);
    return 1'b1;
  endfunction

  function automatic bit m_store(input opcode_t op);
    return op == OP_SW || op == OP_SH || op == OP_SB;
  endfunction

  function automatic logic [3:0] m_be(input opcode_t op, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    if (op == OP_SB) begin
      be = 4'b0000;
      for (int k = 0; k < 4; k++) if (k == int'(off)) be[k] = 1'b1;
    end else if (op == OP_SH) begin
      be = (off == 2'd2) ? 4'b1100 : 4'b0011;
    end
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input opcode_t op, input logic [31:0] d);
    if (op == OP_SH) return (d & 32'h0000FFFF) * 32'h00010001;
    if (op == OP_SB) return (d & 32'h000000FF) * 32'h01010101;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input opcode_t op, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * int'(off));
    case (op)
      OP_LB:   return (sh[7]  ? 32'hFFFFFF00 : 32'h0) | (sh & 32'hFF);
      OP_LBU:  return sh & 32'hFF;
      OP_LH:   return (sh[15] ? 32'hFFFF0000 : 32'h0) | (sh & 32'hFFFF);
      OP_LHU:  return sh & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  // Issue one request, follow it cycle by cycle and compare against the scoreboard.
  task automatic do_access(input string name, input opcode_t op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rdata,
                           input int waits, input bit noise);
    bus_exp_t  be_e;
    done_exp_t de;
    bit        ok;
    int        strobe_cycles;
    ok = m_aligned(op, addr[1:0]);
    if (ok) begin
      be_e.rd = !m_store(op);
      be_e.wr = m_store(op);
      be_e.addr = addr & 32'hFFFFFFFC;
      be_e.be = m_be(op, addr[1:0]);
      be_e.wd = m_wd(op, data);
      be_e.chk_wd = m_store(op);
      bus_q.push_back(be_e);
    end
    de.addr_err = !ok;
    de.bus_err  = ok && (waits >= MAX_WAIT);
    de.load     = m_load(op, addr[1:0], rdata);
    de.chk_load = ok && !m_store(op) && (waits < MAX_WAIT);
    done_q.push_back(de);

    start_i = 1'b1;
    opcode_i = op;
    effective_address_i = addr;
    store_data_i = data;
    mem_waitrequest_i = (waits > 0);
    mem_readdata_i = (waits > 0) ? ~rdata : rdata;
    tick();
    start_i = noise;
    opcode_i = OP_SW;
    effective_address_i = 32'h0000_0500;

    if (ok) begin
      be_e = bus_q.pop_front();
      strobe_cycles = (waits >= MAX_WAIT) ? MAX_WAIT : waits + 1;
      for (int c = 0; c < strobe_cycles; c++) begin
        mem_waitrequest_i = (c < waits);
        mem_readdata_i = (c < waits) ? ~rdata : rdata;
        checks++;
        if (mem_read_o !== be_e.rd || mem_write_o !== be_e.wr || mem_address_o !== be_e.addr ||
            mem_byteenable_o !== be_e.be || (be_e.chk_wd && mem_writedata_o !== be_e.wd) ||
            busy_o !== 1'b1 || done_o !== 1'b0) begin
          failures++;
          $display("FAIL %s bus cyc%0d: got rd=%b wr=%b addr=%h be=%b wd=%h busy=%b done=%b; want rd=%b wr=%b addr=%h be=%b wd=%h busy=1 done=0",
                   name, c, mem_read_o, mem_write_o, mem_address_o, mem_byteenable_o,
                   mem_writedata_o, busy_o, done_o, be_e.rd, be_e.wr, be_e.addr, be_e.be, be_e.wd);
        end
        tick();
      end
    end

    mem_waitrequest_i = 1'b0;
    de = done_q.pop_front();
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || mem_read_o !== 1'b0 || mem_write_o !== 1'b0 ||
        addr_error_o !== de.addr_err || bus_error_o !== de.bus_err) begin
      failures++;
      $display("FAIL %s done: got done=%b busy=%b rd=%b wr=%b aerr=%b berr=%b; want done=1 busy=0 rd=0 wr=0 aerr=%b berr=%b",
               name, done_o, busy_o, mem_read_o, mem_write_o, addr_error_o, bus_error_o,
               de.addr_err, de.bus_err);
    end
    if (de.chk_load) begin
      checks++;
      if (load_data_o !== de.load) begin
        failures++;
        $display("FAIL %s load: got %h want %h", name, load_data_o, de.load);
      end
    end
    tick();
    start_i = 1'b0;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL %s done_width: got done=%b busy=%b want done=0 busy=0", name, done_o, busy_o);
    end
    if (noise) begin
      tick();
      checks++;
      if (mem_read_o !== 1'b0 || mem_write_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL %s ignored_start: got rd=%b wr=%b busy=%b want 0 0 0",
                 name, mem_read_o, mem_write_o, busy_o);
      end
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    start_i = 1'b0;
    opcode_i = OP_LW;
    effective_address_i = 32'h0;
    store_data_i = 32'h0;
    mem_readdata_i = 32'h0;
    mem_waitrequest_i = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy_o, done_o, addr_error_o, bus_error_o, mem_read_o, mem_write_o} !== 6'b0 ||
        load_data_o !== 32'h0 || mem_address_o !== 32'h0 || mem_byteenable_o !== 4'h0 ||
        mem_writedata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: got flags=%b load=%h addr=%h be=%b wd=%h want all zero",
               {busy_o, done_o, addr_error_o, bus_error_o, mem_read_o, mem_write_o},
               load_data_o, mem_address_o, mem_byteenable_o, mem_writedata_o);
    end
    reset_n_i = 1'b1;
    tick();
  endtask

  task automatic test_loads();
    do_access("lw_100",   OP_LW,  32'h0000_0100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    do_access("lb_103",   OP_LB,  32'h0000_0103, 32'h0, 32'h80112233, 0, 1'b0);
    do_access("lbu_103",  OP_LBU, 32'h0000_0103, 32'h0, 32'h80112233, 0, 1'b0);
    do_access("lh_102",   OP_LH,  32'h0000_0102, 32'h0, 32'h9ABC1234, 1, 1'b0);
    do_access("lhu_102",  OP_LHU, 32'h0000_0102, 32'h0, 32'h9ABC1234, 2, 1'b0);
    do_access("lb_101",   OP_LB,  32'h0000_0101, 32'h0, 32'h11225533, 0, 1'b0);
  endtask

  task automatic test_stores();
    do_access("sh_202_wait3", OP_SH, 32'h0000_0202, 32'h1234ABCD, 32'h0, 3, 1'b0);
    do_access("sh_200",       OP_SH, 32'h0000_0200, 32'h1234ABCD, 32'h0, 0, 1'b0);
    do_access("sb_202",       OP_SB, 32'h0000_0202, 32'h000000A5, 32'h0, 0, 1'b0);
    do_access("sw_204",       OP_SW, 32'h0000_0204, 32'h01234567, 32'h0, 1, 1'b0);
  endtask

  task automatic test_misaligned();
    do_access("lw_101",  OP_LW,  32'h0000_0101, 32'h0, 32'h0, 0, 1'b0);
    do_access("sh_203",  OP_SH,  32'h0000_0203, 32'h5555, 32'h0, 0, 1'b0);
    do_access("lhu_201", OP_LHU, 32'h0000_0201, 32'h0, 32'h0, 0, 1'b1);
    do_access("sw_206",  OP_SW,  32'h0000_0206, 32'h0, 32'h0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_access("lw_timeout", OP_LW, 32'h0000_0300, 32'h0, 32'h12345678, 20, 1'b0);
    do_access("sw_timeout", OP_SW, 32'h0000_0304, 32'hFFFF0000, 32'h0, MAX_WAIT, 1'b1);
    do_access("lw_last_wait", OP_LW, 32'h0000_0308, 32'h0, 32'h0BADF00D, MAX_WAIT - 1, 1'b0);
  endtask

  task automatic test_ignored_start();
    do_access("lw_noise", OP_LW, 32'h0000_0400, 32'h0, 32'hA5A5A5A5, 2, 1'b1);
    start_i = 1'b1;
    opcode_i = opcode_t'(4'hF);
    effective_address_i = 32'h0000_0101;
    tick();
    start_i = 1'b0;
    checks++;
    if ({busy_o, done_o, addr_error_o, mem_read_o, mem_write_o} !== 5'b0) begin
      failures++;
      $display("FAIL unsupported_op: got busy=%b done=%b aerr=%b rd=%b wr=%b want all 0",
               busy_o, done_o, addr_error_o, mem_read_o, mem_write_o);
    end
    tick();
    checks++;
    if ({busy_o, done_o, mem_read_o, mem_write_o} !== 4'b0) begin
      failures++;
      $display("FAIL unsupported_op_after: got busy=%b done=%b rd=%b wr=%b want all 0",
               busy_o, done_o, mem_read_o, mem_write_o);
    end
  endtask

  task automatic test_reset_mid_access();
    start_i = 1'b1;
    opcode_i = OP_SW;
    effective_address_i = 32'h0000_0040;
    store_data_i = 32'h11223344;
    mem_waitrequest_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (mem_write_o !== 1'b1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid strobe: got wr=%b busy=%b want 1 1", mem_write_o, busy_o);
    end
    tick();
    #2 reset_n_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, mem_read_o, mem_write_o} !== 4'b0 || mem_address_o !== 32'h0 ||
        mem_byteenable_o !== 4'h0 || mem_writedata_o !== 32'h0 || load_data_o !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid async: got busy=%b done=%b rd=%b wr=%b addr=%h be=%b wd=%h load=%h want all 0",
               busy_o, done_o, mem_read_o, mem_write_o, mem_address_o, mem_byteenable_o,
               mem_writedata_o, load_data_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done_o !== 1'b0 || mem_write_o !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid no_done cyc%0d: got done=%b wr=%b want 0 0", i, done_o, mem_write_o);
      end
    end
    reset_n_i = 1'b1;
    mem_waitrequest_i = 1'b0;
    tick();
    do_access("sw_after_reset", OP_SW, 32'h0000_0044, 32'hCAFEF00D, 32'h0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    opcode_t     op;
    logic [31:0] addr, data, rdata;
    int          waits;
    bit          noise;
    for (int i = 0; i < 16; i++) begin
      op    = opcode_t'(4'($urandom_range(0, 7)));
      addr  = $urandom & 32'h0000_0FFF;
      data  = $urandom;
      rdata = $urandom;
      waits = $urandom_range(0, 2);
      noise = 1'($urandom_range(0, 1));
      do_access($sformatf("rand%0d", i), op, addr, data, rdata, waits, noise);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_ignored_start();
    test_reset_mid_access();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
